instruction_fetch_stage: RTL

- Owns the PC and the IF/ID pipeline register of the 5-stage MIPS core.
- Each cycle it drives the PC to instruction memory and latches the returned word plus PC+4 into IF/ID.
- The IF/ID opcode field feeds the control decoder in ID.
- It applies branch redirects (from EX), jump redirects (from ID), stalls (from hazard unit) and halt, in a fixed priority.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_stat_counter.sv | 32 +++
 rtl/instruction_fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: bubble encoding, fetch state encoding and the
// opcode field values that the decoder in ID already relies on.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/fetch_stat_counter.sv
// Saturating event counter used for fetch statistics; sticks at all-ones
// until reset so a long run never wraps back to a misleading small value.
module fetch_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage of the 5-stage MIPS core: owns the PC and the IF/ID register.
// Optional fetch/bubble statistics are built only when FETCH_STATS_EN is defined.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] StartPC = 32'h0000_0000,
    parameter int          STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset_L,
    output logic [31:0]       InstrAddr,
    input  logic [31:0]       Instruction,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchTarget,
    input  logic              Jump,
    input  logic [25:0]       JumpIndex,
    input  logic              Stall,
    input  logic              Halt,
    output logic [31:0]       IFID_Instr,
    output logic [31:0]       IFID_PCPlus4,
    output logic              IFID_Valid,
    output logic              Halted,
    output logic [STAT_W-1:0] FetchCount,
    output logic [STAT_W-1:0] BubbleCount
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pcplus4_q, ifid_pcplus4_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic         halted_q, halted_d;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect priority in RUN: halt, branch, stall, jump, then sequential fetch.
    // A stalled jump is deliberately dropped; ID re-presents it next cycle.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        ifid_valid_d   = ifid_valid_q;
        halted_d       = halted_q;
        case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (Halt) begin
                    state_d      = FS_HALTED;
                    halted_d     = 1'b1;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (BranchTaken) begin
                    pc_d         = BranchTarget & ~32'h3;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (!Stall) begin
                    if (Jump) begin
                        pc_d         = {ifid_pcplus4_q[31:28], JumpIndex, 2'b00};
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end else begin
                        pc_d           = pc_plus4;
                        ifid_instr_d   = Instruction;
                        ifid_pcplus4_d = pc_plus4;
                        ifid_valid_d   = 1'b1;
                    end
                end
            end
            FS_HALTED: begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q        <= FS_BOOT;
            pc_q           <= StartPC;
            ifid_instr_q   <= NOP_INSTR;
            ifid_pcplus4_q <= 32'h0;
            ifid_valid_q   <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            ifid_valid_q   <= ifid_valid_d;
            halted_q       <= halted_d;
        end
    end

    assign InstrAddr    = pc_q;
    assign IFID_Instr   = ifid_instr_q;
    assign IFID_PCPlus4 = ifid_pcplus4_q;
    assign IFID_Valid   = ifid_valid_q;
    assign Halted       = halted_q;

`ifdef FETCH_STATS_EN
    logic fetch_en;
    logic bubble_en;

    // A held IF/ID during a stall is neither a new fetch nor a new bubble.
    assign fetch_en  = (state_q == FS_RUN) && !Halt && !BranchTaken && !Stall && !Jump;
    assign bubble_en = (state_q == FS_RUN) && (Halt || BranchTaken || (!Stall && Jump));

    fetch_stat_counter #(.W(STAT_W)) u_fetch_cnt (
        .clk   (CLK),
        .rst_n (Reset_L),
        .en    (fetch_en),
        .count (FetchCount)
    );

    fetch_stat_counter #(.W(STAT_W)) u_bubble_cnt (
        .clk   (CLK),
        .rst_n (Reset_L),
        .en    (bubble_en),
        .count (BubbleCount)
    );
`else
    assign FetchCount  = '0;
    assign BubbleCount = '0;
`endif

endmodule
